lfsr_sample_fifo: RTL

Downstream consumer of the LFSR stage. On each rising edge of an asynchronous trigger (button), the block captures a burst of BURST consecutive LFSR output words into a DEPTH-entry FIFO. A valid/ready port exposes the FIFO head to the next consumer. Optionally, the head value is shown on two active-low hex seven-segment digits.

---
 rtl/lfsr_sample_pkg.sv | 40 ++++
 rtl/hex7seg.sv | 15 +
 rtl/lfsr_sample_fifo.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_sample_pkg.sv
// lfsr_sample_pkg: shared types and constants for the LFSR sample FIFO.
// Holds the capture FSM state type, the hex-to-seven-segment table and the
// blank-digit code. Segment codes are active-low with segment a in bit 0
// through segment g in bit 6.
package lfsr_sample_pkg;

    // Capture FSM: idle until a trigger pulse, then stream a burst of words.
    typedef enum logic [0:0] {
        StIdle    = 1'b0,
        StCapture = 1'b1
    } state_t;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low segment codes, indexed by nibble value (entry 15 first).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        return HEX_SEG[nibble];
    endfunction

endpackage

// File: rtl/hex7seg.sv
// hex7seg: decodes one 4-bit nibble into an active-low seven-segment code
// (segment a in bit 0 .. segment g in bit 6). Purely combinational.
module hex7seg
    import lfsr_sample_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; every nibble value has a defined glyph.
    always_comb begin
        seg = hex_to_seg(nibble);
    end

endmodule

// File: rtl/lfsr_sample_fifo.sv
// lfsr_sample_fifo: captures a burst of BURST consecutive LFSR words into a
// DEPTH-entry FIFO on every rising edge of an asynchronous trigger, and
// presents the FIFO head on a valid/ready port.
//
// Parameter constraints: DEPTH is a power of two and at least 2;
// BURST lies in 1..DEPTH.
//
// Optional feature (macro LFSR_SAMPLE_SEG_EN): when defined, seg1/seg0 show
// the high/low nibble of the head on active-low hex digits, blanked while
// empty. When undefined, both digits are tied to blank and no decoders exist.
module lfsr_sample_fifo
    import lfsr_sample_pkg::*;
#(
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned BURST    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_LEN-1:0]     lfsr_in,
    input  logic                    trig,
    output logic [DATA_LEN-1:0]     out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    overflow,
    output logic [6:0]              seg0,
    output logic [6:0]              seg1
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Trigger synchroniser and edge detector
    logic trig_s1;
    logic trig_s2;
    logic trig_s3;
    logic trig_pulse;

    // Capture FSM
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] burst_q;
    logic [CW-1:0] burst_d;
    logic          push;

    // FIFO
    logic [DATA_LEN-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr_q;
    logic [AW-1:0]       rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                overflow_q;
    logic                pop;
    logic                push_ok;

    // ------------------------------------------------------------------
    // Trigger path
    // ------------------------------------------------------------------

    // Two flops resolve metastability; the third delays for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_s3 <= 1'b0;
        end else begin
            trig_s1 <= trig;
            trig_s2 <= trig_s1;
            trig_s3 <= trig_s2;
        end
    end

    // One-cycle pulse per synchronised rising edge.
    assign trig_pulse = trig_s2 & ~trig_s3;

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------

    // State and remaining-word counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
        end
    end

    // Next-state logic. The pulse itself writes the first word; CAPTURE then
    // writes one word per cycle with no gaps. Pulses seen during CAPTURE are
    // dropped so overlapping triggers never lengthen or queue a burst.
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (trig_pulse) begin
                    push = 1'b1;
                    if (BURST > 1) begin
                        state_d = StCapture;
                        burst_d = CW'(BURST - 1);
                    end
                end
            end
            StCapture: begin
                push    = 1'b1;
                burst_d = burst_q - 1'b1;
                if (burst_q == CW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------

    assign out_valid = (count_q != '0);
    assign full      = (count_q == CW'(DEPTH));
    assign pop       = out_valid & out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok   = push & (~full | pop);

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= lfsr_in;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_ok && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push_ok && pop) begin
                count_q <= count_q - 1'b1;
            end
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Head read straight from storage; forced to zero while empty.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = mem[rd_ptr_q];
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

    // ------------------------------------------------------------------
    // Seven-segment display of the head
    // ------------------------------------------------------------------

`ifdef LFSR_SAMPLE_SEG_EN
    logic [7:0] head_byte;
    logic [6:0] seg0_raw;
    logic [6:0] seg1_raw;

    // Zero-extend or truncate the head to the two displayed nibbles.
    assign head_byte = 8'(out_data);

    hex7seg u_seg_lo (
        .nibble (head_byte[3:0]),
        .seg    (seg0_raw)
    );

    hex7seg u_seg_hi (
        .nibble (head_byte[7:4]),
        .seg    (seg1_raw)
    );

    // Blank while empty; otherwise the forced-zero head would show "00".
    always_comb begin
        seg0 = SEG_BLANK;
        seg1 = SEG_BLANK;
        if (out_valid) begin
            seg0 = seg0_raw;
            seg1 = seg1_raw;
        end
    end
`else
    assign seg0 = SEG_BLANK;
    assign seg1 = SEG_BLANK;
`endif

endmodule
